// File: rtl/joypad_arcade_cond_if.sv
// Player-input bundle between the pad source and the arcade conditioner.
// Signals: in_* pad levels, vs_in, turbo_en in; p_* conditioned controls out.
interface joypad_arcade_cond_if;
  logic [3:0] in_dpad;
  logic [3:0] in_joy;
  logic [1:0] in_btn;
  logic       in_se;
  logic       in_st;
  logic       vs_in;
  logic [1:0] turbo_en;
  logic [3:0] p_dir;
  logic [1:0] p_fire;
  logic       p_coin;
  logic       p_start;

  modport master (
    output in_dpad, in_joy, in_btn,
    output in_se, in_st, vs_in, turbo_en,
    input  p_dir, p_fire, p_coin, p_start
  );

  modport slave (
    input  in_dpad, in_joy, in_btn,
    input  in_se, in_st, vs_in, turbo_en,
    output p_dir, p_fire, p_coin, p_start
  );
endinterface

// File: rtl/joypad_arcade_cond.sv
// Arcade control conditioner: debounce, SOCD, frame autofire, coin pulse.
// Ports: clk_sys, reset_n (async low), pad (slave: in_* in, p_* out).
module joypad_arcade_cond #(
  parameter int DB_CYCLES    = 48000,
  parameter int TURBO_FRAMES = 2,
  parameter int COIN_CYCLES  = 480000
) (
  input logic             clk_sys,
  input logic             reset_n,
  joypad_arcade_cond_if.slave pad
);

  localparam int DW = $clog2(DB_CYCLES) + 1;
  localparam int TW = $clog2(TURBO_FRAMES) + 1;
  localparam int CW = $clog2(COIN_CYCLES) + 1;

  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(TURBO_FRAMES - 1);
  localparam logic [CW-1:0] C_LAST  = CW'(COIN_CYCLES - 1);

  typedef enum logic {
    C_IDLE,
    C_BUSY
  } coin_st_t;

  // Line map: [3:0] dir, [5:4] {b,a}, [6] select, [7] start
  logic [7:0]         raw;
  logic [7:0]         db_q, db_d;
  logic [7:0][DW-1:0] dcnt_q, dcnt_d;

  logic [3:0]    dir_q, dir_d;
  logic [1:0]    fire_q, fire_d;
  logic          start_q, start_d;

  logic          vs_q;
  logic          frame_tick;
  logic          any_btn;
  logic [TW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;

  coin_st_t      cst_q, cst_d;
  logic [CW-1:0] ccnt_q, ccnt_d;
  logic          coin_q, coin_d;
  logic          se_q;
  logic          se_rise;

  assign raw = {pad.in_st, pad.in_se, pad.in_btn,
                pad.in_dpad | pad.in_joy};

  // Counter only runs while raw disagrees; any agreement restarts it
  always_comb begin
    db_d   = db_q;
    dcnt_d = '0;
    for (int i = 0; i < 8; i++) begin
      if (raw[i] != db_q[i]) begin
        if (dcnt_q[i] == DB_LAST) begin
          db_d[i] = raw[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Opposing directions cancel each other out
  always_comb begin
    dir_d    = db_q[3:0];
    dir_d[0] = db_q[0] & ~db_q[1];
    dir_d[1] = db_q[1] & ~db_q[0];
    dir_d[2] = db_q[2] & ~db_q[3];
    dir_d[3] = db_q[3] & ~db_q[2];
  end

  assign start_d    = db_q[7];
  assign frame_tick = pad.vs_in & ~vs_q;
  assign any_btn    = |db_q[5:4];

  // Phase parks high while idle so a fresh press fires at once
  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (!any_btn) begin
      fcnt_d  = '0;
      phase_d = 1'b1;
    end else if (frame_tick) begin
      if (fcnt_q == T_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    fire_d = '0;
    for (int i = 0; i < 2; i++) begin
      fire_d[i] = db_q[4+i] &
                  (pad.turbo_en[i] ? phase_q : 1'b1);
    end
  end

  assign se_rise = db_q[6] & ~se_q;

  // Edges arriving while busy are dropped, not queued
  always_comb begin
    cst_d  = cst_q;
    ccnt_d = ccnt_q;
    coin_d = coin_q;
    unique case (cst_q)
      C_IDLE: begin
        if (se_rise) begin
          cst_d  = C_BUSY;
          coin_d = 1'b1;
          ccnt_d = '0;
        end
      end
      C_BUSY: begin
        if (ccnt_q == C_LAST) begin
          cst_d  = C_IDLE;
          coin_d = 1'b0;
          ccnt_d = '0;
        end else begin
          ccnt_d = ccnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      db_q    <= '0;
      dcnt_q  <= '0;
      dir_q   <= '0;
      fire_q  <= '0;
      start_q <= 1'b0;
      vs_q    <= 1'b0;
      fcnt_q  <= '0;
      phase_q <= 1'b1;
      cst_q   <= C_IDLE;
      ccnt_q  <= '0;
      coin_q  <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      db_q    <= db_d;
      dcnt_q  <= dcnt_d;
      dir_q   <= dir_d;
      fire_q  <= fire_d;
      start_q <= start_d;
      vs_q    <= pad.vs_in;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
      cst_q   <= cst_d;
      ccnt_q  <= ccnt_d;
      coin_q  <= coin_d;
      se_q    <= db_q[6];
    end
  end

  assign pad.p_dir   = dir_q;
  assign pad.p_fire  = fire_q;
  assign pad.p_coin  = coin_q;
  assign pad.p_start = start_q;

endmodule

// File: tb/tb_joypad_arcade_cond.sv
// Scoreboard bench for joypad_arcade_cond (DB=4, TURBO=2, COIN=10).
// Observed vector: {p_start, p_coin, p_fire[1:0], p_dir[3:0]}.
module tb_joypad_arcade_cond;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;
  logic [7:0] exp_q[$];
  logic [7:0] obs;

  joypad_arcade_cond_if pad ();

  joypad_arcade_cond #(
    .DB_CYCLES   (4),
    .TURBO_FRAMES(2),
    .COIN_CYCLES (10)
  ) dut (
    .clk_sys(clk),
    .reset_n(rst_n),
    .pad    (pad)
  );

  assign obs = {pad.p_start, pad.p_coin,
                pad.p_fire, pad.p_dir};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] e;
    exp_q.push_back(8'h00);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e)
      $display("FAIL reset_async: got %h want %h", obs, e);
    else passed++;
    exp_q.push_back(8'h00);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (obs !== e)
      $display("FAIL reset_held: got %h want %h", obs, e);
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_debounce();
    logic [7:0] e;
    pad.in_dpad = 4'b0001;
    for (int c = 1; c <= 6; c++) begin
      exp_q.push_back(c >= 5 ? 8'h01 : 8'h00);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL db_press edge %0d: got %h want %h", c, obs, e);
      else passed++;
    end
    pad.in_dpad = 4'b0000;
    for (int c = 1; c <= 6; c++) begin
      exp_q.push_back(c >= 5 ? 8'h00 : 8'h01);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL db_release edge %0d: got %h want %h", c, obs, e);
      else passed++;
    end
    pad.in_dpad = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      if (c == 4) pad.in_dpad = 4'b0000;
      exp_q.push_back(8'h00);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL db_glitch edge %0d: got %h want %h", c, obs, e);
      else passed++;
    end
  endtask

  task automatic test_socd();
    logic [7:0] e;
    pad.in_dpad = 4'b0001;
    pad.in_joy  = 4'b0010;
    for (int c = 1; c <= 8; c++) begin
      exp_q.push_back(8'h00);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL socd_ud edge %0d: got %h want %h", c, obs, e);
      else passed++;
    end
    pad.in_joy = 4'b0000;
    for (int c = 1; c <= 6; c++) begin
      exp_q.push_back(c >= 5 ? 8'h01 : 8'h00);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL socd_rel edge %0d: got %h want %h", c, obs, e);
      else passed++;
    end
    pad.in_dpad = 4'b1001;
    pad.in_joy  = 4'b0100;
    for (int c = 1; c <= 6; c++) begin
      exp_q.push_back(8'h01);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL socd_lr edge %0d: got %h want %h", c, obs, e);
      else passed++;
    end
    pad.in_dpad = 4'b0000;
    pad.in_joy  = 4'b0000;
    for (int c = 1; c <= 6; c++) begin
      exp_q.push_back(c >= 5 ? 8'h00 : 8'h01);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL socd_clear edge %0d: got %h want %h", c, obs, e);
      else passed++;
    end
  endtask

  // vsync high two cycles out of 20 -> frame ticks at edges 11,31,51,...
  task automatic test_autofire();
    logic [7:0] e;
    logic       f;
    int         ed;
    pad.in_btn = 2'b01;
    for (int t = 0; t < 160; t++) begin
      ed = t + 1;
      pad.vs_in    = ((t % 20) == 10) || ((t % 20) == 11);
      pad.turbo_en = (t < 120) ? 2'b01 : 2'b00;
      f = (ed >= 5 && ed <= 31) || (ed >= 72 && ed <= 111) ||
          (ed >= 121);
      exp_q.push_back(f ? 8'h10 : 8'h00);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL autofire edge %0d: got %h want %h", ed, obs, e);
      else passed++;
    end
    pad.vs_in  = 1'b0;
    pad.in_btn = 2'b00;
    for (int c = 1; c <= 6; c++) begin
      exp_q.push_back(c >= 5 ? 8'h00 : 8'h10);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL fire_rel edge %0d: got %h want %h", c, obs, e);
      else passed++;
    end
  endtask

  task automatic test_coin();
    logic [7:0] e;
    pad.in_se = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      exp_q.push_back((c >= 5 && c <= 14) ? 8'h40 : 8'h00);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL coin_hold edge %0d: got %h want %h", c, obs, e);
      else passed++;
    end
    pad.in_se = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      exp_q.push_back(8'h00);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL coin_gap edge %0d: got %h want %h", c, obs, e);
      else passed++;
    end
    pad.in_se = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      exp_q.push_back((c >= 5 && c <= 14) ? 8'h40 : 8'h00);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL coin_again edge %0d: got %h want %h", c, obs, e);
      else passed++;
    end
    pad.in_se = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      exp_q.push_back(8'h00);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL coin_drain edge %0d: got %h want %h", c, obs, e);
      else passed++;
    end
  endtask

  // Second debounced Select edge lands at edge 14, inside the pulse
  task automatic test_coin_busy();
    logic [7:0] e;
    for (int t = 0; t < 40; t++) begin
      pad.in_se = (t < 5) || (t >= 9);
      exp_q.push_back((t + 1 >= 5 && t + 1 <= 14) ? 8'h40 : 8'h00);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL coin_busy edge %0d: got %h want %h", t + 1, obs, e);
      else passed++;
    end
    pad.in_se = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      exp_q.push_back(8'h00);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL busy_drain edge %0d: got %h want %h", c, obs, e);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    pad.turbo_en = 2'b01;
    pad.in_btn   = 2'b01;
    pad.in_se    = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      exp_q.push_back(c >= 5 ? 8'h50 : 8'h00);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL rst_pre edge %0d: got %h want %h", c, obs, e);
      else passed++;
    end
    #2;
    rst_n = 1'b0;
    exp_q.push_back(8'h00);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e)
      $display("FAIL rst_mid_async: got %h want %h", obs, e);
    else passed++;
    @(negedge clk);
    exp_q.push_back(8'h00);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (obs !== e)
      $display("FAIL rst_mid_held: got %h want %h", obs, e);
    else passed++;
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      if (c <= 4) exp_q.push_back(8'h00);
      else if (c <= 14) exp_q.push_back(8'h50);
      else exp_q.push_back(8'h10);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL rst_post edge %0d: got %h want %h", c, obs, e);
      else passed++;
    end
    pad.in_btn   = 2'b00;
    pad.in_se    = 1'b0;
    pad.turbo_en = 2'b00;
    for (int c = 1; c <= 6; c++) begin
      exp_q.push_back(c >= 5 ? 8'h00 : 8'h10);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL rst_drain edge %0d: got %h want %h", c, obs, e);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    pad.in_st   = 1'b1;
    pad.in_btn  = 2'b10;
    pad.in_dpad = 4'b1000;
    for (int c = 1; c <= 8; c++) begin
      exp_q.push_back(c >= 5 ? 8'hA8 : 8'h00);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL b2b_press edge %0d: got %h want %h", c, obs, e);
      else passed++;
    end
    pad.in_st   = 1'b0;
    pad.in_btn  = 2'b00;
    pad.in_dpad = 4'b0000;
    for (int c = 1; c <= 6; c++) begin
      exp_q.push_back(c >= 5 ? 8'h00 : 8'hA8);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL b2b_release edge %0d: got %h want %h", c, obs, e);
      else passed++;
    end
  endtask

  initial begin
    checks       = 0;
    passed       = 0;
    rst_n        = 1'b0;
    pad.in_dpad  = '0;
    pad.in_joy   = '0;
    pad.in_btn   = '0;
    pad.in_se    = 1'b0;
    pad.in_st    = 1'b0;
    pad.vs_in    = 1'b0;
    pad.turbo_en = '0;
    test_reset();
    test_debounce();
    test_socd();
    test_autofire();
    test_coin();
    test_coin_busy();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
